// File: rtl/tfaw_tracker_mr_if.sv
// Command-issue and tFAW status bundle between the ACT scheduler and the tFAW tracker.
interface tfaw_tracker_mr_if #(
  parameter int CMD_TYPE_WIDTH        = 3,
  parameter int NUM_RANKS             = 2,
  parameter int RANK_BITS             = 1,
  parameter int TIME_CONSTRAINT_WIDTH = 8,
  parameter int CNT_WIDTH             = 3
);
  // Handshake: a command is issued in any cycle where cmd_valid_i=1; there is no
  // ready, the tracker observes every command and can only flag (never stall) it.
  logic                                       cmd_valid_i;
  logic [CMD_TYPE_WIDTH-1:0]                  cmd_type_i;
  logic [RANK_BITS-1:0]                       cmd_rank_i;
  logic [TIME_CONSTRAINT_WIDTH-1:0]           tfaw_cfg_i;
  logic                                       faw_en_i;
  logic [NUM_RANKS-1:0]                       act_allowed_o;
  logic [NUM_RANKS*TIME_CONSTRAINT_WIDTH-1:0] faw_wait_o;
  logic [NUM_RANKS*CNT_WIDTH-1:0]             act_cnt_o;
  logic                                       faw_viol_o;
  logic                                       faw_viol_sticky_o;

  modport master (
    output cmd_valid_i, cmd_type_i, cmd_rank_i, tfaw_cfg_i, faw_en_i,
    input  act_allowed_o, faw_wait_o, act_cnt_o, faw_viol_o, faw_viol_sticky_o
  );

  modport slave (
    input  cmd_valid_i, cmd_type_i, cmd_rank_i, tfaw_cfg_i, faw_en_i,
    output act_allowed_o, faw_wait_o, act_cnt_o, faw_viol_o, faw_viol_sticky_o
  );
endinterface

// File: rtl/tfaw_tracker_mr.sv
// Multi-rank tFAW tracker: per-rank countdown slots, one per ACT allowed in the window.
// Status outputs are derived from registered slot state only (plus the enable bypass).
module tfaw_tracker_mr #(
  parameter int                        CMD_TYPE_WIDTH        = 3,
  parameter logic [CMD_TYPE_WIDTH-1:0] ACT_BITS              = 3'b010,
  parameter int                        NUM_RANKS             = 2,
  parameter int                        RANK_BITS             = 1,
  parameter int                        ACT_WINDOW            = 4,
  parameter int                        TIME_CONSTRAINT_WIDTH = 8,
  parameter int                        CNT_WIDTH             = 3
) (
  input logic              clk,
  input logic              rst_n,
  tfaw_tracker_mr_if.slave bus
);
  localparam int TW = TIME_CONSTRAINT_WIDTH;

  logic [TW-1:0]        cnt_q [NUM_RANKS][ACT_WINDOW];
  logic [TW-1:0]        cnt_d [NUM_RANKS][ACT_WINDOW];
  logic                 viol_q;
  logic                 sticky_q;
  logic                 viol_d;
  logic                 is_act;
  logic                 rank_free;
  logic [NUM_RANKS-1:0] free;
  logic [TW-1:0]        load_val;

  always_comb begin
    is_act    = bus.cmd_valid_i && (bus.cmd_type_i == ACT_BITS) && bus.faw_en_i &&
                (int'(bus.cmd_rank_i) < NUM_RANKS);
    load_val  = (bus.tfaw_cfg_i == '0) ? '0 : bus.tfaw_cfg_i - TW'(1);
    free      = '0;
    rank_free = 1'b0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      for (int s = 0; s < ACT_WINDOW; s++) begin
        if (cnt_q[r][s] == '0) free[r] = 1'b1;
      end
      if (RANK_BITS'(r) == bus.cmd_rank_i) rank_free = free[r];
    end
    viol_d = is_act && !rank_free;
  end

  // Decrement everything, then let an accepted ACT claim the lowest free slot of its rank.
  always_comb begin
    logic found;
    for (int r = 0; r < NUM_RANKS; r++) begin
      found = 1'b0;
      for (int s = 0; s < ACT_WINDOW; s++) begin
        cnt_d[r][s] = (cnt_q[r][s] == '0) ? '0 : cnt_q[r][s] - TW'(1);
        if (is_act && (RANK_BITS'(r) == bus.cmd_rank_i) && !found && (cnt_q[r][s] == '0)) begin
          cnt_d[r][s] = load_val;
          found       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [TW-1:0]        min_v;
    logic [CNT_WIDTH-1:0] busy;
    bus.act_allowed_o = '1;
    bus.faw_wait_o    = '0;
    bus.act_cnt_o     = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      min_v = '1;
      busy  = '0;
      for (int s = 0; s < ACT_WINDOW; s++) begin
        if (cnt_q[r][s] < min_v) min_v = cnt_q[r][s];
        if (cnt_q[r][s] != '0) busy = busy + CNT_WIDTH'(1);
      end
      bus.act_allowed_o[r]           = !bus.faw_en_i || free[r];
      bus.faw_wait_o[r*TW +: TW]     = free[r] ? '0 : min_v;
      bus.act_cnt_o[r*CNT_WIDTH +: CNT_WIDTH] = busy;
    end
    bus.faw_viol_o        = viol_q;
    bus.faw_viol_sticky_o = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '{default: '0};
      viol_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      viol_q   <= viol_d;
      sticky_q <= sticky_q | viol_d;
    end
  end
endmodule

// File: tb/tb_tfaw_tracker_mr.sv
// Directed bench for tfaw_tracker_mr: a short hand-computed vector table (cfg 2..9)
// plus long-window sequences at cfg=36 for the fill, violation, reuse and bypass cases.
module tb_tfaw_tracker_mr;
  localparam logic [2:0] ACT = 3'b010;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  tfaw_tracker_mr_if #(.CMD_TYPE_WIDTH(3), .NUM_RANKS(2), .RANK_BITS(1),
                       .TIME_CONSTRAINT_WIDTH(8), .CNT_WIDTH(3)) bus ();

  tfaw_tracker_mr #(.CMD_TYPE_WIDTH(3), .ACT_BITS(3'b010), .NUM_RANKS(2), .RANK_BITS(1),
                    .ACT_WINDOW(4), .TIME_CONSTRAINT_WIDTH(8), .CNT_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic       valid;
    logic [2:0] typ;
    logic       rank;
    logic [7:0] cfg;
    logic       en;
    logic [1:0] e_allowed;
    logic [15:0] e_wait;
    logic [5:0] e_cnt;
    logic       e_viol;
    logic       e_sticky;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic rk,
                       input logic [7:0] cfg, input logic en, input logic rn);
    bus.cmd_valid_i = v;
    bus.cmd_type_i  = t;
    bus.cmd_rank_i  = rk;
    bus.tfaw_cfg_i  = cfg;
    bus.faw_en_i    = en;
    rst_n           = rn;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Rank0 filled at cfg=36 in cycles 0..3, optionally one more ACT to rank0 at 'extra'.
  task automatic scen_fill(input int extra);
    do_reset();
    for (int c = 0; c < 40; c++) begin
      drive((c < 4) || (c == extra), ACT, 1'b0, 8'd36, 1'b1, 1'b1);
      @(negedge clk);
      if (c >= 4 && c <= 35) begin
        chk("fill_allowed0", bus.act_allowed_o[0], 1'b0);
        chk("fill_cnt0", bus.act_cnt_o[2:0], 3'd4);
      end
      if (c == 4)  chk("fill_wait0_c4", bus.faw_wait_o[7:0], 8'd32);
      if (c == 35) chk("fill_wait0_c35", bus.faw_wait_o[7:0], 8'd1);
      if (c == 36) chk("fill_open_c36", bus.act_allowed_o[0], 1'b1);
      chk("fill_allowed1", bus.act_allowed_o[1], 1'b1);
      chk("fill_cnt1", bus.act_cnt_o[5:3], 3'd0);
      if (extra == 10) begin
        if (c == 10 || c == 12) chk("viol_idle", bus.faw_viol_o, 1'b0);
        if (c == 11) chk("viol_pulse", bus.faw_viol_o, 1'b1);
        if (c >= 11) chk("viol_sticky", bus.faw_viol_sticky_o, 1'b1);
      end
      if (extra == 36 && c == 37) begin
        chk("reuse_viol", bus.faw_viol_o, 1'b0);
        chk("reuse_sticky", bus.faw_viol_sticky_o, 1'b0);
        chk("reuse_allowed0", bus.act_allowed_o[0], 1'b1);
        // ACT@36 occupies a slot but ACT@1's slot frees in this same cycle: 3 busy.
        chk("reuse_cnt0", bus.act_cnt_o[2:0], 3'd3);
        chk("reuse_wait0", bus.faw_wait_o[7:0], 8'd0);
      end
      if (extra < 0 && c == 39) chk("fill_no_sticky", bus.faw_viol_sticky_o, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  // Rank0 filled, then bypass from cycle 8 with ACTs every cycle; optional reset at rst_cyc.
  task automatic scen_bypass(input int rst_cyc);
    int  last;
    logic en;
    last = (rst_cyc >= 0) ? 21 : 40;
    for (int c = 0; c <= last; c++) begin
      en = (c < 8) || (rst_cyc >= 0 && c > rst_cyc);
      drive((c < 4) || (c >= 8), ACT, 1'b0, 8'd36, en, !(c == rst_cyc));
      @(negedge clk);
      if (c >= 8 && !en) begin
        chk("byp_allowed", bus.act_allowed_o, 2'b11);
        chk("byp_viol", bus.faw_viol_o, 1'b0);
      end
      if (rst_cyc < 0) begin
        if (c == 8)  chk("byp_cnt0_c8", bus.act_cnt_o[2:0], 3'd4);
        if (c == 38) chk("byp_cnt0_c38", bus.act_cnt_o[2:0], 3'd1);
        if (c == 39) chk("byp_cnt0_c39", bus.act_cnt_o[2:0], 3'd0);
        if (c == 40) chk("byp_sticky", bus.faw_viol_sticky_o, 1'b0);
      end else begin
        if (c == 20) chk("rst_cnt0_before", bus.act_cnt_o[2:0], 3'd4);
        if (c == 21) begin
          chk("rst_allowed", bus.act_allowed_o, 2'b11);
          chk("rst_cnt", bus.act_cnt_o, 6'd0);
          chk("rst_wait", bus.faw_wait_o, 16'd0);
          chk("rst_viol", bus.faw_viol_o, 1'b0);
          chk("rst_sticky", bus.faw_viol_sticky_o, 1'b0);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //            rn  v  typ     rk  cfg  en  allowed wait          cnt{r1,r0}      viol st
    tbl[0]  = '{1'b1,1'b1,ACT,   1'b0,8'd5,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd0},1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,ACT,   1'b0,8'd5,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd1},1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,ACT,   1'b1,8'd3,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd2},1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,ACT,   1'b0,8'd5,1'b1,2'b11,{8'd0,8'd0},{3'd1,3'd2},1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b1,ACT,   1'b0,8'd5,1'b1,2'b11,{8'd0,8'd0},{3'd1,3'd3},1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b1,ACT,   1'b0,8'd5,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd3},1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b1,ACT,   1'b0,8'd2,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd3},1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,ACT,   1'b0,8'd2,1'b1,2'b10,{8'd0,8'd1},{3'd0,3'd4},1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,3'b001,1'b0,8'd9,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd2},1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,ACT,   1'b0,8'd9,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd1},1'b0,1'b0};
    tbl[10] = '{1'b1,1'b1,ACT,   1'b0,8'd9,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd1},1'b0,1'b0};
    tbl[11] = '{1'b1,1'b1,ACT,   1'b0,8'd9,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd2},1'b0,1'b0};
    tbl[12] = '{1'b1,1'b1,ACT,   1'b0,8'd9,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd3},1'b0,1'b0};
    tbl[13] = '{1'b1,1'b1,ACT,   1'b0,8'd9,1'b1,2'b10,{8'd0,8'd5},{3'd0,3'd4},1'b0,1'b0};
    tbl[14] = '{1'b1,1'b0,ACT,   1'b0,8'd9,1'b1,2'b10,{8'd0,8'd4},{3'd0,3'd4},1'b1,1'b1};
    tbl[15] = '{1'b1,1'b1,ACT,   1'b0,8'd9,1'b0,2'b11,{8'd0,8'd3},{3'd0,3'd4},1'b0,1'b1};
    tbl[16] = '{1'b0,1'b0,ACT,   1'b0,8'd9,1'b1,2'b10,{8'd0,8'd2},{3'd0,3'd4},1'b0,1'b1};
    tbl[17] = '{1'b1,1'b0,ACT,   1'b0,8'd9,1'b1,2'b11,{8'd0,8'd0},{3'd0,3'd0},1'b0,1'b0};

    do_reset();
    @(negedge clk);
    chk("reset_allowed", bus.act_allowed_o, 2'b11);
    chk("reset_wait", bus.faw_wait_o, 16'd0);
    chk("reset_cnt", bus.act_cnt_o, 6'd0);
    chk("reset_viol", bus.faw_viol_o, 1'b0);
    chk("reset_sticky", bus.faw_viol_sticky_o, 1'b0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].valid, tbl[i].typ, tbl[i].rank, tbl[i].cfg, tbl[i].en, tbl[i].rn);
      @(negedge clk);
      chk($sformatf("vec%0d_allowed", i), bus.act_allowed_o, tbl[i].e_allowed);
      chk($sformatf("vec%0d_wait", i), bus.faw_wait_o, tbl[i].e_wait);
      chk($sformatf("vec%0d_cnt", i), bus.act_cnt_o, tbl[i].e_cnt);
      chk($sformatf("vec%0d_viol", i), bus.faw_viol_o, tbl[i].e_viol);
      chk($sformatf("vec%0d_sticky", i), bus.faw_viol_sticky_o, tbl[i].e_sticky);
      @(posedge clk);
      #1;
    end

    scen_fill(-1);
    scen_fill(10);
    scen_fill(36);

    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 10; c++) begin
        drive(1'b1, ACT, 1'b1, (k == 0) ? 8'd1 : 8'd0, 1'b1, 1'b1);
        @(negedge clk);
        chk("short_allowed1", bus.act_allowed_o[1], 1'b1);
        chk("short_viol", bus.faw_viol_o, 1'b0);
        chk("short_cnt1", bus.act_cnt_o[5:3], 3'd0);
        @(posedge clk);
        #1;
      end
    end
    chk("short_sticky", bus.faw_viol_sticky_o, 1'b0);

    do_reset();
    scen_bypass(-1);
    do_reset();
    scen_bypass(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
